// File: rtl/sipo_deser_if.sv
// rtl/sipo_deser_if.sv - serial input, parallel output and status bundle for the deserializer
interface sipo_deser_if #(
    parameter int WIDTH = 8
);
    logic             sin;
    logic             sin_vld;
    logic             sof;
    logic [WIDTH-1:0] dout;
    logic             dout_vld;
    logic             dout_rdy;
    logic             busy;
    logic             ovr_err;
    logic             sync_err;
    logic             err_clr;

    modport master (
        output sin, sin_vld, sof, dout_rdy, err_clr,
        input  dout, dout_vld, busy, ovr_err, sync_err
    );

    modport slave (
        input  sin, sin_vld, sof, dout_rdy, err_clr,
        output dout, dout_vld, busy, ovr_err, sync_err
    );
endinterface

// File: rtl/sipo_deser.sv
// rtl/sipo_deser.sv - framed serial-in/parallel-out deserializer with holding register
module sipo_deser #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    sipo_deser_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] dout_q;
    logic             dout_vld_q;
    logic             busy_q;
    logic             ovr_q;
    logic             sync_q;

    logic             start;
    logic             resync;
    logic             complete;
    logic             accept;
    logic [CW-1:0]    bit_idx;
    logic [CW-1:0]    pos;
    logic [WIDTH-1:0] shift_d;
    logic             ovr_d;
    logic             sync_d;

    // shift_d is the shift register with the current bit merged in; on a
    // sof bit the stale partial word is wiped first.
    always_comb begin
        start    = bus.sin_vld && bus.sof;
        resync   = (state_q == SHIFT) && start;
        complete = (state_q == SHIFT) && bus.sin_vld && !bus.sof && (cnt_q == LAST);
        accept   = dout_vld_q && bus.dout_rdy;
        bit_idx  = start ? '0 : cnt_q;
        pos      = MSB_FIRST ? (LAST - bit_idx) : bit_idx;
        shift_d  = start ? '0 : shift_q;
        shift_d[pos] = bus.sin;
        ovr_d    = (complete && dout_vld_q && !bus.dout_rdy) || (ovr_q && !bus.err_clr);
        sync_d   = resync || (sync_q && !bus.err_clr);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            busy_q     <= 1'b0;
            ovr_q      <= 1'b0;
            sync_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shift_q <= shift_d;
                        cnt_q   <= CW'(1);
                        state_q <= SHIFT;
                        busy_q  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (bus.sin_vld) begin
                        if (bus.sof) begin
                            shift_q <= shift_d;
                            cnt_q   <= CW'(1);
                        end else if (complete) begin
                            shift_q <= '0;
                            cnt_q   <= '0;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            shift_q <= shift_d;
                            cnt_q   <= cnt_q + CW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            // A full holding register that is not being drained drops the
            // new word; dout stays put so the consumer sees a stable value.
            if (complete) begin
                if (!dout_vld_q || bus.dout_rdy) begin
                    dout_q     <= shift_d;
                    dout_vld_q <= 1'b1;
                end
            end else if (accept) begin
                dout_vld_q <= 1'b0;
            end

            ovr_q  <= ovr_d;
            sync_q <= sync_d;
        end
    end

    assign bus.dout     = dout_q;
    assign bus.dout_vld = dout_vld_q;
    assign bus.busy     = busy_q;
    assign bus.ovr_err  = ovr_q;
    assign bus.sync_err = sync_q;
endmodule
